img_spawn_queue: RTL and testbench

Consumer for the 2-bit random image index stream. Each `dclk` it samples the random source. It filters out values that are out of range or that would exceed the allowed repeat run, and buffers accepted indices in a small FIFO. Game logic pops the next image index from the FIFO with a valid/pop handshake.

---
 rtl/img_pkg.sv | 15 +
 rtl/idx_fifo.sv | 72 +++++++
 rtl/img_spawn_queue.sv | 90 +++++++++
 tb/tb_img_spawn_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared types and constants for the image spawn queue.
package img_pkg;

  localparam int IMG_IDX_W   = 2;
  localparam int DEF_NUM_IMG = 3;

  typedef logic [IMG_IDX_W-1:0] img_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } spawn_state_t;

endpackage

// File: rtl/idx_fifo.sv
// DEPTH x 2-bit synchronous FIFO whose head index is held in a register,
// so a push into an empty FIFO is visible the cycle after the edge.
module idx_fifo
  import img_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   dclk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  img_idx_t               din,
  output img_idx_t               dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

  img_idx_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  img_idx_t         dout_reg, dout_next;
  logic             valid_reg;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != DEPTH_C) || do_pop);

  always_comb begin
    rd_ptr_next = rd_ptr_reg + {{(PTR_W-1){1'b0}}, do_pop};
    count_next  = count_reg + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    dout_next   = dout_reg;
    // A sole surviving entry that is being written right now is not in mem yet.
    if (count_next != '0)
      dout_next = (do_push && count_next == ONE_C) ? din : mem[rd_ptr_next];
  end

  always_ff @(posedge dclk) begin
    if (do_push && !flush)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      dout_reg   <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + {{(PTR_W-1){1'b0}}, do_push};
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      valid_reg  <= (count_next != '0);
      dout_reg   <= dout_next;
    end
  end

  assign dout  = dout_reg;
  assign valid = valid_reg;
  assign count = count_reg;

endmodule

// File: rtl/img_spawn_queue.sv
// Filters the random image index stream (range and repeat-run rules) into a
// small FIFO. Define IMG_SPAWN_STATS_EN to build the saturating reject counter.
module img_spawn_queue
  import img_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int NUM_IMG = DEF_NUM_IMG,
  parameter int MAX_RUN = 2
) (
  input  logic                   dclk,
  input  logic                   rst,
  input  logic [IMG_IDX_W-1:0]   rnd_in,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   pop,
  output logic [IMG_IDX_W-1:0]   img_idx,
  output logic                   img_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             reject_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [2:0]       MAX_RUN_C = 3'(MAX_RUN);

  spawn_state_t state;
  img_idx_t     last_idx_reg;
  logic [2:0]   run_len_reg;
  logic         pop_ok, range_ok, run_ok, room, push;

  // Operating state is a pure decode of enable and the current occupancy.
  always_comb begin
    state = IDLE;
    if (enable)
      state = (count == DEPTH_C) ? FULL : FILL;
  end

  assign pop_ok   = pop && img_valid;
  assign range_ok = 32'(rnd_in) < NUM_IMG;
  assign run_ok   = !((rnd_in == last_idx_reg) && (run_len_reg == MAX_RUN_C));
  assign room     = (state != FULL) || pop_ok;
  assign push     = (state != IDLE) && !flush && range_ok && run_ok && room;

  always_ff @(posedge dclk) begin
    if (rst) begin
      last_idx_reg <= '0;
      run_len_reg  <= '0;
    end else if (flush) begin
      run_len_reg  <= '0;
    end else if (push) begin
      if (rnd_in == last_idx_reg) begin
        run_len_reg  <= run_len_reg + 3'd1;
      end else begin
        last_idx_reg <= rnd_in;
        run_len_reg  <= 3'd1;
      end
    end
  end

  idx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .dclk  (dclk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop_ok),
    .din   (rnd_in),
    .dout  (img_idx),
    .valid (img_valid),
    .count (count)
  );

`ifdef IMG_SPAWN_STATS_EN
  logic [7:0] reject_cnt_reg;

  // Only filter-rule rejections count; samples lost to a full FIFO do not.
  always_ff @(posedge dclk) begin
    if (rst)
      reject_cnt_reg <= '0;
    else if (enable && !flush && !(range_ok && run_ok) && reject_cnt_reg != 8'hFF)
      reject_cnt_reg <= reject_cnt_reg + 8'd1;
  end

  assign reject_cnt = reject_cnt_reg;
`else
  assign reject_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_img_spawn_queue.sv
// Randomized plus directed bench for img_spawn_queue against a queue-based model.
module tb_img_spawn_queue;

  localparam int DEPTH   = 4;
  localparam int NUM_IMG = 3;
  localparam int MAX_RUN = 2;
`ifdef IMG_SPAWN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       dclk = 1'b0;
  logic       rst = 1'b1, enable = 1'b0, flush = 1'b0, pop = 1'b0;
  logic [1:0] rnd_in = 2'd0;
  logic [1:0] img_idx;
  logic       img_valid;
  logic [2:0] count;
  logic [7:0] reject_cnt;

  always #5 dclk = ~dclk;

  img_spawn_queue #(
    .DEPTH   (DEPTH),
    .NUM_IMG (NUM_IMG),
    .MAX_RUN (MAX_RUN)
  ) dut (
    .dclk       (dclk),
    .rst        (rst),
    .rnd_in     (rnd_in),
    .enable     (enable),
    .flush      (flush),
    .pop        (pop),
    .img_idx    (img_idx),
    .img_valid  (img_valid),
    .count      (count),
    .reject_cnt (reject_cnt)
  );

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  int mq[$];
  int m_last = 0, m_run = 0, m_rej = 0, m_hold = 0;

  function automatic int rej_exp(input int v);
    return STATS ? v : 0;
  endfunction

  function automatic void check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Reference: the FIFO is a queue, the rules applied literally per sample.
  always @(posedge dclk) begin : model
    bit popok, rng, runok, acc;
    if (rst) begin
      mq.delete();
      m_last = 0; m_run = 0; m_rej = 0; m_hold = 0;
    end else if (flush) begin
      mq.delete();
      m_run = 0;
    end else begin
      popok = pop && (mq.size() > 0);
      rng   = int'(rnd_in) < NUM_IMG;
      runok = !((int'(rnd_in) == m_last) && (m_run == MAX_RUN));
      acc   = enable && rng && runok && ((mq.size() < DEPTH) || popok);
      if (enable && !(rng && runok) && m_rej < 255) m_rej++;
      if (popok) begin
        $display("pop idx=%0d left=%0d", mq[0], mq.size() - 1);
        void'(mq.pop_front());
      end
      if (acc) begin
        mq.push_back(int'(rnd_in));
        if (int'(rnd_in) == m_last) m_run++;
        else begin
          m_last = int'(rnd_in);
          m_run  = 1;
        end
      end
      if (mq.size() > 0) m_hold = mq[0];
    end
  end

  always @(negedge dclk) begin
    if (chk_on) begin
      check("img_valid", int'(img_valid), (mq.size() > 0) ? 1 : 0);
      check("count", int'(count), mq.size());
      check("img_idx", int'(img_idx), m_hold);
      check("reject_cnt", int'(reject_cnt), rej_exp(m_rej));
    end
  end

  task automatic cyc(input bit en, input int rnd, input bit fl, input bit pp);
    enable = en;
    rnd_in = 2'(rnd);
    flush  = fl;
    pop    = pp;
    @(negedge dclk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic pop_chk(input string nm, input int exp);
    check(nm, int'(img_idx), exp);
    cyc(0, 0, 0, 1);
  endtask

  initial begin
    int pop_pct;
    do_reset();
    chk_on = 1'b1;
    check("rst_valid", int'(img_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_idx", int'(img_idx), 0);
    check("rst_rej", int'(reject_cnt), 0);

    // A: fill 0,1,2,0 then full blocks, drain in order
    cyc(1, 0, 0, 0);
    check("A_valid1", int'(img_valid), 1);
    check("A_idx1", int'(img_idx), 0);
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0); cyc(1, 0, 0, 0);
    check("A_count4", int'(count), 4);
    cyc(1, 1, 0, 0);
    check("A_fullblk", int'(count), 4);
    check("A_fullrej", int'(reject_cnt), 0);
    pop_chk("A_pop0", 0); pop_chk("A_pop1", 1); pop_chk("A_pop2", 2); pop_chk("A_pop3", 0);
    check("A_empty", int'(img_valid), 0);

    // B: out-of-range held
    do_reset();
    repeat (10) cyc(1, 3, 0, 0);
    check("B_rej", int'(reject_cnt), rej_exp(10));
    check("B_valid", int'(img_valid), 0);

    // C: repeat-run limit
    do_reset();
    repeat (5) cyc(1, 1, 0, 0);
    check("C_count", int'(count), 2);
    check("C_rej", int'(reject_cnt), rej_exp(3));
    cyc(1, 1, 0, 0);
    check("C_run_hold", int'(count), 2);
    cyc(1, 0, 0, 0);
    check("C_newidx", int'(count), 3);

    // D: full with simultaneous pop and push wraps the tail
    do_reset();
    cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 1);
    check("D_count", int'(count), 4);
    check("D_head", int'(img_idx), 1);
    pop_chk("D_pop0", 1); pop_chk("D_pop1", 0); pop_chk("D_pop2", 1); pop_chk("D_pop3", 2);
    check("D_empty", int'(img_valid), 0);

    // E: flush beats pop and clears run history
    do_reset();
    cyc(1, 0, 0, 0); cyc(1, 2, 0, 0); cyc(1, 2, 0, 0);
    cyc(1, 2, 1, 1);
    check("E_count", int'(count), 0);
    check("E_valid", int'(img_valid), 0);
    cyc(1, 2, 0, 0);
    check("E_acc", int'(count), 1);
    check("E_idx", int'(img_idx), 2);

    // F: disabled period retains contents
    do_reset();
    cyc(1, 1, 0, 0); cyc(1, 2, 0, 0);
    repeat (20) cyc(0, int'($urandom_range(0, 3)), 0, 0);
    check("F_count", int'(count), 2);
    check("F_rej", int'(reject_cnt), 0);
    pop_chk("F_pop0", 1); pop_chk("F_pop1", 2);
    check("F_empty", int'(img_valid), 0);

    // G: random traffic with varying pop pressure
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      pop_pct = (i / 500) % 3 == 0 ? 20 : ((i / 500) % 3 == 1 ? 50 : 80);
      cyc($urandom_range(0, 9) != 0, int'($urandom_range(0, 3)),
          $urandom_range(0, 63) == 0, $urandom_range(0, 99) < pop_pct);
    end
    check("G_sat", int'(reject_cnt), rej_exp(255));

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
